// File: rtl/sm_addsub_pipe.sv
// sm_addsub_pipe
//   Two-stage, multi-lane sign-magnitude add/subtract unit with a shared
//   valid/ready handshake. Each lane word is {sign, magnitude[WIDTH-1:0]}.
//   Stage 1 registers normalised magnitudes, effective signs and the
//   magnitude compare. Stage 2 registers the result and the overflow flag.
//
// Parameters
//   WIDTH : magnitude bits per lane
//   LANES : independent lanes sharing one handshake
//   SAT   : 1 = saturate magnitude on overflow, 0 = wrap (drop the carry)
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : operand-set handshake
//   a, b              : packed operands, lane i at [i*(WIDTH+1) +: WIDTH+1]
//   sub               : per-lane mode, 1 = a-b, 0 = a+b
//   out_valid/out_ready : result handshake
//   sum, ovf          : packed per-lane result and magnitude-overflow flag
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both 1. A producer holding valid keeps its data stable until that edge.
// ready never depends on the matching valid. Here the pipeline stalls only
// when a result is waiting and the consumer refuses it, so in_ready is the
// combinational inverse of that condition and full-rate flow is possible.
module sm_addsub_pipe #(
   parameter int WIDTH = 16,
   parameter int LANES = 1,
   parameter int SAT   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*(WIDTH+1)-1:0] a,
   input  logic [LANES*(WIDTH+1)-1:0] b,
   input  logic [LANES-1:0]         sub,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*(WIDTH+1)-1:0] sum,
   output logic [LANES-1:0]         ovf
);

   localparam int LW = WIDTH + 1;

   logic stall;
   logic s1_valid;

   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   // Both stages advance together; an empty stage 1 still moves forward,
   // so bubbles are preserved rather than collapsed.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
      end else if (!stall) begin
         s1_valid  <= in_valid;
         out_valid <= s1_valid;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [WIDTH-1:0] a_mag_in;
      logic [WIDTH-1:0] b_mag_in;
      logic             a_sgn_in;
      logic             b_sgn_in;

      logic [WIDTH-1:0] s1_a_mag;
      logic [WIDTH-1:0] s1_b_mag;
      logic             s1_a_sgn;
      logic             s1_b_sgn;
      logic             s1_gt;
      logic             s1_eq;
      logic             s1_same;

      logic [WIDTH:0]   raw;
      logic [WIDTH-1:0] nxt_mag;
      logic             nxt_sgn;
      logic             nxt_ovf;

      logic [WIDTH-1:0] sum_mag;
      logic             sum_sgn;
      logic             ovf_r;

      assign a_mag_in = a[i*LW +: WIDTH];
      assign b_mag_in = b[i*LW +: WIDTH];
      // -0 is folded to +0 here so the sign logic downstream never sees it.
      assign a_sgn_in = a[i*LW + WIDTH] & (|a_mag_in);
      assign b_sgn_in = (b[i*LW + WIDTH] ^ sub[i]) & (|b_mag_in);

      always_ff @(posedge clk) begin
         if (rst) begin
            s1_a_mag <= '0;
            s1_b_mag <= '0;
            s1_a_sgn <= 1'b0;
            s1_b_sgn <= 1'b0;
            s1_gt    <= 1'b0;
            s1_eq    <= 1'b0;
            s1_same  <= 1'b0;
         end else if (!stall) begin
            s1_a_mag <= a_mag_in;
            s1_b_mag <= b_mag_in;
            s1_a_sgn <= a_sgn_in;
            s1_b_sgn <= b_sgn_in;
            s1_gt    <= (a_mag_in > b_mag_in);
            s1_eq    <= (a_mag_in == b_mag_in);
            s1_same  <= (a_sgn_in == b_sgn_in);
         end
      end

      always_comb begin
         raw     = {1'b0, s1_a_mag} + {1'b0, s1_b_mag};
         nxt_mag = '0;
         nxt_sgn = 1'b0;
         nxt_ovf = 1'b0;
         if (s1_same) begin
            nxt_sgn = s1_a_sgn;
            nxt_ovf = raw[WIDTH];
            if (raw[WIDTH] && (SAT != 0)) begin
               nxt_mag = '1;
            end else begin
               nxt_mag = raw[WIDTH-1:0];
            end
         end else if (s1_eq) begin
            nxt_mag = '0;
            nxt_sgn = 1'b0;
         end else if (s1_gt) begin
            nxt_mag = s1_a_mag - s1_b_mag;
            nxt_sgn = s1_a_sgn;
         end else begin
            nxt_mag = s1_b_mag - s1_a_mag;
            nxt_sgn = s1_b_sgn;
         end
         // A wrapped sum can land on zero; zero is always reported as +0.
         if (nxt_mag == '0) begin
            nxt_sgn = 1'b0;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            sum_mag <= '0;
            sum_sgn <= 1'b0;
            ovf_r   <= 1'b0;
         end else if (!stall) begin
            sum_mag <= nxt_mag;
            sum_sgn <= nxt_sgn;
            ovf_r   <= nxt_ovf;
         end
      end

      assign sum[i*LW +: LW] = {sum_sgn, sum_mag};
      assign ovf[i]          = ovf_r;
   end

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Directed bench for sm_addsub_pipe. One single-lane saturating instance
// and one four-lane wrapping instance. Drivers push hand-computed results
// into per-instance expected queues; monitors pop and compare on every
// output transfer.
module tb_sm_addsub_pipe;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // single lane, SAT=1
   logic        in_valid1, in_ready1, sub1, out_valid1, out_ready1, ovf1;
   logic [16:0] a1, b1, sum1;

   // four lanes, SAT=0
   logic        in_valid4, in_ready4, out_valid4, out_ready4;
   logic [67:0] a4, b4, sum4;
   logic [3:0]  sub4, ovf4;

   int total = 0;
   int bad   = 0;

   logic [17:0] exp1_q[$];
   logic [71:0] exp4_q[$];
   logic [17:0] e1;
   logic [71:0] e4;
   logic [17:0] hold;

   sm_addsub_pipe #(.WIDTH(16), .LANES(1), .SAT(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .sub(sub1), .out_valid(out_valid1),
      .out_ready(out_ready1), .sum(sum1), .ovf(ovf1));

   sm_addsub_pipe #(.WIDTH(16), .LANES(4), .SAT(0)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .sub(sub4), .out_valid(out_valid4),
      .out_ready(out_ready4), .sum(sum4), .ovf(ovf4));

   function automatic logic [16:0] sm(input bit s, input int m);
      return {s, m[15:0]};
   endfunction

   task automatic check(input string name, input logic [71:0] act,
                        input logic [71:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // ---------------- monitors / scoreboard ----------------
   always @(negedge clk) begin
      if (!rst && out_valid1 && out_ready1) begin
         if (exp1_q.size() == 0) begin
            total++; bad++;
            $display("FAIL mon1_extra: got %0h want nothing", {ovf1, sum1});
         end else begin
            e1 = exp1_q.pop_front();
            check("mon1_result", {54'd0, ovf1, sum1}, {54'd0, e1});
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && out_valid4 && out_ready4) begin
         if (exp4_q.size() == 0) begin
            total++; bad++;
            $display("FAIL mon4_extra: got %0h want nothing", {ovf4, sum4});
         end else begin
            e4 = exp4_q.pop_front();
            check("mon4_result", {ovf4, sum4}, e4);
         end
      end
   end

   // ---------------- drivers ----------------
   // Called at #1 after a rising edge; returns #1 after the accepting edge.
   task automatic send1(input logic [16:0] av, input logic [16:0] bv,
                        input logic s, input logic [16:0] es, input logic eo);
      bit acc = 1'b0;
      in_valid1 = 1'b1; a1 = av; b1 = bv; sub1 = s;
      for (int k = 0; k < 50 && !acc; k++) begin
         @(negedge clk);
         acc = in_ready1;
         @(posedge clk);
      end
      if (acc) exp1_q.push_back({eo, es});
      else begin
         total++; bad++;
         $display("FAIL send1_timeout: got in_ready=0 want accept");
      end
      #1;
   endtask

   task automatic send4(input logic [67:0] av, input logic [67:0] bv,
                        input logic [3:0] s, input logic [67:0] es,
                        input logic [3:0] eo);
      bit acc = 1'b0;
      in_valid4 = 1'b1; a4 = av; b4 = bv; sub4 = s;
      for (int k = 0; k < 50 && !acc; k++) begin
         @(negedge clk);
         acc = in_ready4;
         @(posedge clk);
      end
      if (acc) exp4_q.push_back({eo, es});
      else begin
         total++; bad++;
         $display("FAIL send4_timeout: got in_ready=0 want accept");
      end
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && (exp1_q.size() != 0 || exp4_q.size() != 0); k++)
         @(posedge clk);
      @(posedge clk); #1;
      check("drain_q1", exp1_q.size(), 0);
      check("drain_q4", exp4_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      in_valid1 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b0; out_ready1 = 1'b1;
      in_valid4 = 1'b0; a4 = '0; b4 = '0; sub4 = '0;  out_ready4 = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_valid1", out_valid1, 1'b0);
      check("reset_res1", {ovf1, sum1}, 18'd0);
      check("reset_res4", {out_valid4, ovf4, sum4}, 73'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // latency: two register stages, result visible after the edge that
      // follows the accepting edge, and only for one cycle
      send1(sm(0, 5), sm(1, 3), 1'b0, sm(0, 2), 1'b0);
      in_valid1 = 1'b0;
      @(negedge clk); check("lat_after_accept", out_valid1, 1'b0);
      @(negedge clk); check("lat_result", out_valid1, 1'b1);
      @(negedge clk); check("lat_gone", out_valid1, 1'b0);
      @(posedge clk); #1;

      // back-to-back directed vectors
      send1(sm(0, 3),       sm(0, 5),       1'b1, sm(1, 2),       1'b0);
      send1(sm(1, 7),       sm(1, 7),       1'b1, sm(0, 0),       1'b0);
      send1(sm(1, 0),       sm(0, 0),       1'b1, sm(0, 0),       1'b0);
      send1(sm(0, 'hFFFF),  sm(0, 2),       1'b0, sm(0, 'hFFFF),  1'b1);
      send1(sm(1, 'h8000),  sm(0, 'h8000),  1'b1, sm(1, 'hFFFF),  1'b1);
      send1(sm(0, 'h8000),  sm(1, 'h7FFF),  1'b1, sm(0, 'hFFFF),  1'b0);
      in_valid1 = 1'b0;
      drain();

      // backpressure while streaming
      fork
         begin
            for (int k = 1; k <= 6; k++)
               send1(sm(0, k), sm(0, 10), 1'b0, sm(0, 10 + k), 1'b0);
            in_valid1 = 1'b0;
         end
         begin
            repeat (3) @(posedge clk);
            #1 out_ready1 = 1'b0;
            @(negedge clk);
            hold = {ovf1, sum1};
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               check("stall_valid", out_valid1, 1'b1);
               check("stall_in_ready", in_ready1, 1'b0);
               check("stall_hold", {ovf1, sum1}, hold);
            end
            @(posedge clk); #1 out_ready1 = 1'b1;
         end
      join
      drain();

      // reset with two sets in flight and the output stalled
      out_ready1 = 1'b0;
      send1(sm(0, 1), sm(0, 1), 1'b0, sm(0, 2), 1'b0);
      send1(sm(0, 2), sm(0, 2), 1'b0, sm(0, 4), 1'b0);
      rst = 1'b1;
      a1 = sm(0, 99); b1 = sm(0, 1); sub1 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b1;
      exp1_q.delete();
      @(negedge clk);
      check("rst_valid", out_valid1, 1'b0);
      check("rst_res", {ovf1, sum1}, 18'd0);
      check("rst_in_ready", in_ready1, 1'b1);
      @(posedge clk); #1;
      send1(sm(0, 20), sm(0, 50), 1'b1, sm(1, 30), 1'b0);
      in_valid1 = 1'b0;
      @(negedge clk); check("post_rst_early", out_valid1, 1'b0);
      @(negedge clk); check("post_rst_result", out_valid1, 1'b1);
      @(posedge clk); #1;
      drain();

      // four independent wrapping lanes, packed {lane3, lane2, lane1, lane0}
      send4({sm(1, 7), sm(0, 'hFFFF), sm(0, 3), sm(0, 100)},
            {sm(1, 7), sm(0, 2),      sm(0, 5), sm(1, 30)},
            4'b1010,
            {sm(0, 0), sm(0, 1),      sm(1, 2), sm(0, 70)}, 4'b0100);
      send4({sm(1, 5), sm(1, 0), sm(0, 'h10), sm(1, 'h8000)},
            {sm(1, 9), sm(0, 0), sm(1, 'h20), sm(0, 'h8000)},
            4'b1001,
            {sm(0, 4), sm(0, 0), sm(1, 'h10), sm(0, 0)}, 4'b0001);
      send4({sm(1, 0), sm(0, 'hFFFF), sm(0, 1),      sm(0, 'hFFFF)},
            {sm(1, 0), sm(1, 'hFFFF), sm(0, 'hFFFF), sm(0, 1)},
            4'b1111,
            {sm(0, 0), sm(0, 'hFFFE), sm(1, 'hFFFE), sm(0, 'hFFFE)}, 4'b0100);
      in_valid4 = 1'b0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
